gyro_seq: RTL and testbench

Sequencer that owns the SPI monarch on behalf of the inertial sensor. After power-up it issues a fixed three-write configuration sequence, then services the sensor's data-ready interrupt. On each interrupt it performs two single-register reads and assembles a 16-bit yaw-rate sample for the heading integrator. It drives the monarch's `snd`/`cmd` inputs and consumes its sticky `done` flag and 16-bit `resp`.

---
 rtl/gyro_seq.sv | 160 ++++++++++++++++
 tb/tb_gyro_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_seq.sv
// SPI sequencer for the inertial sensor: power-up wait, three configuration writes,
// then a read-L/read-H pair per data-ready interrupt, assembling a signed yaw-rate sample.
module gyro_seq #(
    parameter int unsigned PWR_UP_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_i,
    input  logic        done_i,
    input  logic [15:0] resp_i,
    output logic        snd_o,
    output logic [15:0] cmd_o,
    output logic        init_done_o,
    output logic [15:0] yaw_rt_o,
    output logic        vld_o
);

    localparam logic [15:0] PwrUpLast = 16'(PWR_UP_CYC - 1);

    localparam logic [15:0] CmdInt1Ctrl = 16'h0D02;
    localparam logic [15:0] CmdCtrl2G   = 16'h1160;
    localparam logic [15:0] CmdCtrl5    = 16'h1440;
    localparam logic [15:0] CmdRdZL     = 16'hA600;
    localparam logic [15:0] CmdRdZH     = 16'hA700;

    typedef enum logic [2:0] {
        StPwrUp,
        StWr1,
        StWr2,
        StWr3,
        StIdle,
        StRdL,
        StRdH
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [2:0]  int_sync_q;
    logic        done_q;
    logic        snd_q, snd_d;
    logic [15:0] cmd_q, cmd_d;
    logic        init_done_q, init_done_d;
    logic [7:0]  yaw_l_q, yaw_l_d;
    logic [15:0] yaw_q, yaw_d;
    logic        vld_q, vld_d;

    logic int_re;
    logic done_re;

    // Stage 2 vs stage 3 compare: only metastability-filtered INT reaches the FSM.
    assign int_re  = int_sync_q[1] & ~int_sync_q[2];
    // A level-high sticky done is never a completion; only its rising edge is.
    assign done_re = done_i & ~done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snd_d       = 1'b0;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        yaw_l_d     = yaw_l_q;
        yaw_d       = yaw_q;
        vld_d       = 1'b0;
        pend_d      = pend_q | (int_re & init_done_q & (state_q != StIdle));

        case (state_q)
            StPwrUp: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == PwrUpLast) begin
                    snd_d   = 1'b1;
                    cmd_d   = CmdInt1Ctrl;
                    state_d = StWr1;
                end
            end
            StWr1: begin
                if (done_re) begin
                    snd_d   = 1'b1;
                    cmd_d   = CmdCtrl2G;
                    state_d = StWr2;
                end
            end
            StWr2: begin
                if (done_re) begin
                    snd_d   = 1'b1;
                    cmd_d   = CmdCtrl5;
                    state_d = StWr3;
                end
            end
            StWr3: begin
                if (done_re) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                if (pend_q || int_re) begin
                    snd_d   = 1'b1;
                    cmd_d   = CmdRdZL;
                    pend_d  = 1'b0;
                    state_d = StRdL;
                end
            end
            StRdL: begin
                if (done_re) begin
                    yaw_l_d = resp_i[7:0];
                    snd_d   = 1'b1;
                    cmd_d   = CmdRdZH;
                    state_d = StRdH;
                end
            end
            StRdH: begin
                if (done_re) begin
                    yaw_d   = {resp_i[7:0], yaw_l_q};
                    vld_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StPwrUp;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPwrUp;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            int_sync_q  <= '0;
            done_q      <= 1'b0;
            snd_q       <= 1'b0;
            cmd_q       <= '0;
            init_done_q <= 1'b0;
            yaw_l_q     <= '0;
            yaw_q       <= '0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            int_sync_q  <= {int_sync_q[1:0], int_i};
            done_q      <= done_i;
            snd_q       <= snd_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            yaw_l_q     <= yaw_l_d;
            yaw_q       <= yaw_d;
            vld_q       <= vld_d;
        end
    end

    assign snd_o       = snd_q;
    assign cmd_o       = cmd_q;
    assign init_done_o = init_done_q;
    assign yaw_rt_o    = yaw_q;
    assign vld_o       = vld_q;

endmodule

// File: tb/tb_gyro_seq.sv
// Scoreboard bench for gyro_seq: stimulus queues expected SPI commands and samples,
// a monitor pops and checks them (value and cycle timing) whenever snd or vld appears.
module tb_gyro_seq;

    localparam int unsigned PWR = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_s = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        snd;
    logic [15:0] cmd;
    logic        init_done;
    logic [15:0] yaw_rt;
    logic        vld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = -100;
    int int_rise = -100;
    int lat = 40;
    bit stale = 1'b0;

    // kind: 0 absolute power-up cycle, 1 done rise + 1, 2 INT latency window, 3 done rise + 2
    typedef struct {
        logic [15:0] cmd;
        int          kind;
    } exp_t;

    exp_t        sq[$];
    logic [15:0] yq[$];
    logic [15:0] rq[$];
    exp_t        e;

    gyro_seq #(.PWR_UP_CYC(PWR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_i      (int_s),
        .done_i     (done),
        .resp_i     (resp),
        .snd_o      (snd),
        .cmd_o      (cmd),
        .init_done_o(init_done),
        .yaw_rt_o   (yaw_rt),
        .vld_o      (vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every snd and every vld must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && snd) begin
            if (sq.size() == 0) begin
                fail("unexpected_snd");
                $display("  cmd was 0x%0h", cmd);
            end else begin
                e = sq.pop_front();
                chk("snd_cmd", cmd, e.cmd);
                case (e.kind)
                    0: chk("snd_cyc_pwrup", cyc, PWR);
                    1: chk("snd_after_done", cyc, last_rise + 1);
                    2: chk("int_latency_ok", ((cyc - int_rise) >= 3 && (cyc - int_rise) <= 4), 1);
                    default: chk("snd_pending", cyc, last_rise + 2);
                endcase
            end
        end
        if (rst_n && vld) begin
            if (yq.size() == 0) begin
                fail("unexpected_vld");
            end else begin
                chk("yaw_rt", yaw_rt, yq.pop_front());
                chk("vld_cyc", cyc, last_rise + 1);
            end
        end
    end

    // SPI monarch model: sticky done, cleared a cycle after snd (or late in stale mode).
    initial begin
        int k;
        bit busy;
        busy = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                done = 1'b0;
            end else if (snd) begin
                busy = 1'b1;
                k = 0;
                if (!stale) done = 1'b0;
            end else if (busy) begin
                k++;
                if (stale && k == 8) done = 1'b0;
                if (k == lat) begin
                    resp = (rq.size() != 0) ? rq.pop_front() : 16'hDEAD;
                    done = 1'b1;
                    last_rise = cyc;
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_int(input int n);
        int_s = 1'b1;
        int_rise = cyc;
        idle(n);
        int_s = 1'b0;
        idle(n);
    endtask

    task automatic expect_pwrup();
        sq.push_back('{16'h0D02, 0});
        sq.push_back('{16'h1160, 1});
        sq.push_back('{16'h1440, 1});
        repeat (3) rq.push_back(16'h0000);
    endtask

    task automatic wait_sq(input int n, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (sq.size() <= n) break;
            @(negedge clk);
        end
        if (i == max) fail("timeout_wait_cmd");
    endtask

    task automatic drain(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (sq.size() == 0 && yq.size() == 0) break;
            @(negedge clk);
        end
        if (i == max) fail("timeout_drain");
    endtask

    task automatic wait_init(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (init_done) break;
            @(negedge clk);
        end
        if (i == max) fail("timeout_init_done");
        else chk("init_done_cyc", cyc, last_rise + 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_snd"}, snd, 0);
        chk({tag, "_cmd"}, cmd, 16'h0000);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_yaw_rt"}, yaw_rt, 16'h0000);
        chk({tag, "_vld"}, vld, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        idle(3);
        chk_reset_outputs("reset");

        // Power-up with INT pulses during PWRUP and WR2 that must be discarded
        expect_pwrup();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        pulse_int(3);
        wait_sq(1, 2000);
        pulse_int(3);
        wait_init(2000);
        idle(30);
        chk("no_read_before_int", sq.size(), 0);

        // First sample
        sq.push_back('{16'hA600, 2});
        sq.push_back('{16'hA700, 1});
        rq.push_back(16'h00A5);
        rq.push_back(16'h00FE);
        yq.push_back(16'hFEA5);
        int_s = 1'b1;
        int_rise = cyc;
        drain(500);
        int_s = 1'b0;
        idle(10);
        chk("yaw_rt_hold", yaw_rt, 16'hFEA5);

        // Three INT edges while busy collapse to one extra pair; resp high bytes ignored
        sq.push_back('{16'hA600, 2});
        sq.push_back('{16'hA700, 1});
        sq.push_back('{16'hA600, 3});
        sq.push_back('{16'hA700, 1});
        rq.push_back(16'hFF11);
        rq.push_back(16'h0022);
        rq.push_back(16'h5533);
        rq.push_back(16'hAB44);
        yq.push_back(16'h2211);
        yq.push_back(16'h4433);
        int_s = 1'b1;
        int_rise = cyc;
        wait_sq(3, 100);
        int_s = 1'b0;
        idle(3);
        repeat (3) pulse_int(3);
        drain(1000);
        idle(60);
        chk("collapse_yaw_hold", yaw_rt, 16'h4433);

        // Stale done: sticky done stays high into the next snd, then drops and rises
        stale = 1'b1;
        lat = 14;
        sq.push_back('{16'hA600, 2});
        sq.push_back('{16'hA700, 1});
        rq.push_back(16'h0077);
        rq.push_back(16'h0066);
        yq.push_back(16'h6677);
        int_s = 1'b1;
        int_rise = cyc;
        drain(500);
        int_s = 1'b0;
        stale = 1'b0;
        lat = 40;
        idle(20);

        // Reset in the middle of RDL
        sq.push_back('{16'hA600, 2});
        rq.push_back(16'h1234);
        int_s = 1'b1;
        int_rise = cyc;
        wait_sq(0, 100);
        idle(5);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        int_s = 1'b0;
        idle(2);
        rq.delete();
        expect_pwrup();
        rst_n = 1'b1;
        wait_init(2000);
        drain(200);
        idle(40);
        chk("replay_yaw_rt", yaw_rt, 16'h0000);

        chk("sq_empty", sq.size(), 0);
        chk("yq_empty", yq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
